// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter that replaces a full barrel shifter.
// Supports SLL, SRL, SRA and ROR on a WIDTH-bit operand under a
// start/busy/done handshake. By default it moves one bit position per clock.
// Optional build macro SEQ_SHIFTER_FAST_EN: each clock moves up to four
// positions, so long shifts finish in about a quarter of the cycles.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   In,
  output logic [WIDTH-1:0]   Out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  // Largest useful shift amount; larger requests are clamped to this value.
  localparam logic [SHAMT_W-1:0] MAX_AMT = SHAMT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         mode_q, mode_d;

  // Single-position shift according to the operation code.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       m);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (m)
      M_SLL:   r = {v[WIDTH-2:0], 1'b0};
      M_SRL:   r = {1'b0, v[WIDTH-1:1]};
      M_SRA:   r = sv >>> 1;
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Clamp the requested amount to WIDTH-1.
  function automatic logic [SHAMT_W-1:0] clamp_amt(input logic [SHAMT_W-1:0] a);
    logic [SHAMT_W-1:0] r;
    if (int'(a) > WIDTH - 1) r = MAX_AMT;
    else                     r = a;
    return r;
  endfunction

`ifdef SEQ_SHIFTER_FAST_EN
  logic [SHAMT_W-1:0] step;

  // Positions to move this cycle: min(count, 4).
  function automatic logic [SHAMT_W-1:0] step_amt(input logic [SHAMT_W-1:0] c);
    logic [SHAMT_W-1:0] r;
    if (int'(c) > 4) r = SHAMT_W'(4);
    else             r = c;
    return r;
  endfunction

  // Apply the single-position rule k times (k <= 4).
  function automatic logic [WIDTH-1:0] shift_k(input logic [WIDTH-1:0]   v,
                                               input logic [1:0]         m,
                                               input logic [SHAMT_W-1:0] k);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(k)) r = shift_one(r, m);
    end
    return r;
  endfunction
`endif

  // Next-state and next-datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    mode_d  = mode_q;
`ifdef SEQ_SHIFTER_FAST_EN
    step    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          out_d   = In;
          mode_d  = mode;
          count_d = clamp_amt(shamt);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == '0) begin
          // Out already holds the final result; just announce it.
          state_d = DONE;
        end else begin
`ifdef SEQ_SHIFTER_FAST_EN
          step    = step_amt(count_q);
          out_d   = shift_k(out_q, mode_q, step);
          count_d = count_q - step;
`else
          out_d   = shift_one(out_q, mode_q);
          count_d = count_q - SHAMT_W'(1);
`endif
        end
      end
      DONE: begin
        // Starts arriving here are deliberately ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, abandoning any shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      count_q <= '0;
      mode_q  <= M_SLL;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized self-checking bench for seq_shifter with a behavioural model.
module tb_seq_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   din;
  logic [WIDTH-1:0]   dout;
  logic               busy;
  logic               done;

  int nchecks;
  int nfail;

  seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .In    (din),
    .Out   (dout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference result computed with plain arithmetic.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input int n,
                                             input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0] r;
    sv = v;
    case (m)
      2'b00: r = v << n;
      2'b01: r = v >> n;
      2'b10: r = sv >>> n;
      default: r = (n == 0) ? v : ((v >> n) | (v << (WIDTH - n)));
    endcase
    return r;
  endfunction

  function automatic int model_lat(input int n);
`ifdef SEQ_SHIFTER_FAST_EN
    return (n + 3) / 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // One complete transaction; optional pokes of start while busy and in DONE.
  task automatic run_op(input logic [1:0] m, input int sa, input logic [WIDTH-1:0] v,
                        input bit poke, input string tag);
    logic [WIDTH-1:0] exp;
    int n, edges, nobusy;
    bit got;
    n   = (sa > WIDTH - 1) ? WIDTH - 1 : sa;
    exp = model(m, n, v);
    @(negedge clk);
    start = 1'b1; mode = m; shamt = SHAMT_W'(sa); din = v;
    @(posedge clk); #1;
    chk({tag, "_busy_acc"}, busy, 1);
    start = poke; din = poke ? {WIDTH{1'b1}} : WIDTH'($urandom);
    mode = 2'($urandom); shamt = SHAMT_W'($urandom);
    edges = 0; got = 0; nobusy = 0;
    while (!got && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (done) got = 1;
      else if (!busy) nobusy++;
    end
    chk({tag, "_timeout"}, got, 1);
    chk({tag, "_lat"}, edges, model_lat(n));
    chk({tag, "_out"}, dout, exp);
    chk({tag, "_busy_hold"}, nobusy, 0);
    chk({tag, "_busy_done"}, busy, 1);
    if (poke) begin
      start = 1'b1; din = {WIDTH{1'b1}};
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_hold"}, dout, exp);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    int nd;
    nchecks = 0; nfail = 0;
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; shamt = '0; din = '0;
    #12;
    chk("rst_out", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("post_rst_quiet", nd, 0);

    // Directed cases.
    run_op(2'b00, 2,  32'h00000001, 0, "sll2");
    run_op(2'b10, 4,  32'hF0F0F0F0, 0, "sra4");
    run_op(2'b01, 4,  32'hF0F0F0F0, 0, "srl4");
    run_op(2'b11, 1,  32'hAAAAAAAA, 0, "ror1");
    run_op(2'b00, 0,  32'h0000000F, 0, "sll0");
    run_op(2'b00, 3,  32'h00000002, 1, "poke");
    run_op(2'b01, 31, 32'h80000000, 0, "srl31");
    run_op(2'b10, 31, 32'h80000000, 0, "sra31");
    run_op(2'b11, 31, 32'h12345678, 1, "ror31");

    // Reset in the middle of a long shift.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; shamt = 5'd31; din = 32'h80000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out", dout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run_op(2'b00, 1, 32'h00000001, 0, "after_rst");

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), int'($urandom_range(0, 31)), WIDTH'($urandom),
             bit'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the fixed combinational left-shift-by-2 used in the datapath.
- Performs logical left, logical right, arithmetic right or rotate-right on a WIDTH-bit operand by a runtime shift amount.
- Processes the shift iteratively, one bit per cycle, under a start/done handshake.
- Used by the multi-cycle execution unit for shift instructions; it replaces a full barrel shifter to save area.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥ 2.
- SHAMT_W, 5, shift-amount width. Must satisfy 2^SHAMT_W ≥ WIDTH. Amounts ≥ WIDTH are clamped to WIDTH-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse. Sampled only when busy=0.
- mode  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- shamt  input  SHAMT_W  shift amount.
- In  input  WIDTH  operand.
- Out  output  WIDTH  result register. Holds its value until the next accepted start.
- busy  output  1  high from accepted start until the done cycle (inclusive).
- done  output  1  one-cycle pulse when Out is valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, Out=0, busy=0, done=0, internal count=0, latched mode=00.
- Deasserting reset returns the block to IDLE on the next edge with no spurious done.
- State IDLE:
  - start=1 at an edge loads Out←In, latches mode and count←min(shamt, WIDTH-1), sets busy=1, goes to SHIFT.
  - mode/shamt/In are ignored after acceptance.
- State SHIFT, count≠0: at each edge Out shifts by 1 per the latched mode, and count decrements.
  - SLL: fill LSB with 0.
  - SRL: fill MSB with 0.
  - SRA: MSB replicated.
  - ROR: Out[0] moves to Out[WIDTH-1].
- State SHIFT, count=0: go to DONE; Out unchanged.
- State DONE: done=1 and busy=1 for exactly one cycle. At the next edge go to IDLE, done=0, busy=0.
  - A start in DONE is ignored; start must be presented in IDLE.
- Latency: with start sampled at edge E0 and shamt=N (after clamping), done is high in the cycle following edge E(N+1), i.e. N+2 edges from start to return to IDLE.
  - N=0: done follows after one edge, Out=In.
- start while busy=1: ignored; no effect on Out, count or mode.
- Reset mid-operation: abandons the shift immediately; Out clears to 0; no done is produced.
- Out is only written in IDLE (on accepted start) and SHIFT. It is stable during DONE and IDLE.

Optional Feature:
- Macro: SEQ_SHIFTER_FAST_EN.
- When defined: in SHIFT each edge shifts by k=min(count,4) positions (same fill/rotate rules applied k times) and count decreases by k. Latency becomes ceil(N/4)+1 edges to done; N=0 is unchanged.
- When undefined: one position per edge as above.
- Port list, reset values and handshake are identical in both builds.

Test Plan:
- SLL, In=0x00000001, shamt=2 → Out=0x00000004; done 3 edges after start.
- SRA, In=0xF0F0F0F0, shamt=4 → Out=0xFF0F0F0F; done 5 edges after start. SRL with the same inputs → 0x0F0F0F0F.
- ROR, In=0xAAAAAAAA, shamt=1 → Out=0x55555555. SLL, In=0x0000000F, shamt=0 → Out=0x0000000F; done 1 edge after start.
- Start (SLL, In=0x2, shamt=3), then pulse start with In=0xFFFFFFFF while busy → Out=0x00000010, exactly one done pulse.
- Start SRL, In=0x80000000, shamt=31; drop rst_n after 5 edges → Out=0, busy=0, done never asserted. After release, a new start (SLL, In=0x1, shamt=1) gives Out=0x2.
- SEQ_SHIFTER_FAST_EN defined: SRL, In=0x80000000, shamt=31 → Out=0x00000001, done 9 edges after start (32 edges without the macro).
